// File: rtl/tmec_decode_ibm_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tmec_decode_ibm_seq
//  Purpose  : Self-sequenced inversionless Berlekamp-Massey key-equation
//             solver for binary BCH codes over GF(2^M). Takes all 2T
//             syndromes in one beat and returns a scaled error-locator
//             polynomial, the final BM length and an uncorrectable flag.
//  Ports    : clk        rising-edge clock
//             reset      synchronous active-high reset
//             start      request, accepted only while idle
//             syn        S1..S2T, S_i at [(i-1)*M +: M]
//             busy       high from accept until done
//             done       one-cycle pulse, results valid from this cycle
//             lambda     locator coefficients, Lambda_i at [i*M +: M]
//             err_count  final BM length L
//             fail       uncorrectable indication
//  Revision : 1.0  initial release
// ============================================================================
module tmec_decode_ibm_seq #(
    parameter int M = 4,
    parameter int T = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [2*T*M-1:0]           syn,
    output logic                       busy,
    output logic                       done,
    output logic [(T+1)*M-1:0]         lambda,
    output logic [$clog2(2*T+1)-1:0]   err_count,
    output logic                       fail
);

    localparam int c_LW = $clog2(2*T+1);   // width of L / err_count
    localparam int c_RW = $clog2(T);       // iteration counter 0..T-1
    localparam int c_JW = $clog2(T+1);     // coefficient counter 0..T

    // Primitive polynomials of the polynomial-basis field, one per degree.
    localparam int c_POLY = (M == 2)  ? 32'h7   :
                            (M == 3)  ? 32'hB   :
                            (M == 4)  ? 32'h13  :
                            (M == 5)  ? 32'h25  :
                            (M == 6)  ? 32'h43  :
                            (M == 7)  ? 32'h89  :
                            (M == 8)  ? 32'h11D :
                            (M == 9)  ? 32'h211 :
                            (M == 10) ? 32'h409 :
                            (M == 11) ? 32'h805 :
                                        32'h1053;
    localparam logic [M-1:0]         c_POLY_LOW   = c_POLY[M-1:0];
    localparam logic [M-1:0]         c_ONE        = M'(1);
    localparam logic [(T+1)*M-1:0]   c_LAMBDA_ONE = ((T+1)*M)'(1);

    // Shift-and-add GF(2^M) multiply with modular reduction each step.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a,
                                            input logic [M-1:0] b);
        logic [M-1:0] acc;
        logic [M-1:0] aa;
        acc = '0;
        aa  = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = aa[M-1] ? ((aa << 1) ^ c_POLY_LOW) : (aa << 1);
        end
        return acc;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DISC = 2'd1,
        S_UPD  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [2*T*M-1:0]       r_syn;
    logic [M-1:0]           r_lam [0:T];
    logic [M-1:0]           r_b   [0:T];
    logic [M-1:0]           r_gamma;
    logic [M-1:0]           r_delta;
    logic [c_LW-1:0]        r_len;
    logic [c_RW-1:0]        r_r;
    logic [c_JW-1:0]        r_j;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_fail;
    logic [c_LW-1:0]        r_err;
    logic [(T+1)*M-1:0]     r_lambda;

    logic [M-1:0]           w_lam_sel;
    logic [M-1:0]           w_syn_sel;
    logic [M-1:0]           w_prod;
    logic [M-1:0]           w_lam_upd [0:T];
    logic [M-1:0]           w_b_upd   [0:T];
    logic                   w_swap;
    logic [c_LW-1:0]        w_len_new;
    logic [c_JW-1:0]        w_deg;
    logic                   w_lam_zero;
    logic                   w_fail;
    logic [(T+1)*M-1:0]     w_lam_packed;

    // ------------------------------------------------------------------
    // Control FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin : p_next_state
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_state_next = S_DISC;
            S_DISC:  if (r_j == c_JW'(T)) w_state_next = S_UPD;
            S_UPD:   w_state_next = (r_r == c_RW'(T-1)) ? S_FIN : S_DISC;
            S_FIN:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Serial discrepancy term: Lambda_j * S_(2r+1-j), S_k = 0 for k < 1
    // ------------------------------------------------------------------
    always_comb begin : p_disc_sel
        w_lam_sel = '0;
        w_syn_sel = '0;
        for (int i = 0; i <= T; i++) begin
            if (r_j == c_JW'(i)) w_lam_sel = r_lam[i];
        end
        for (int k = 1; k <= 2*T; k++) begin
            if ((2*int'(r_r) + 1 - int'(r_j)) == k) w_syn_sel = r_syn[(k-1)*M +: M];
        end
    end

    assign w_prod = gf_mul(w_lam_sel, w_syn_sel);

    // ------------------------------------------------------------------
    // Parallel polynomial update
    // ------------------------------------------------------------------
    always_comb begin : p_update
        // 2L <= 2r reduces to L <= r
        w_swap    = (r_delta != '0) && (r_len <= c_LW'(r_r));
        w_len_new = c_LW'({r_r, 1'b1}) - r_len;
        for (int i = 0; i <= T; i++) begin
            w_lam_upd[i] = gf_mul(r_gamma, r_lam[i]);
            w_b_upd[i]   = '0;
        end
        for (int i = 1; i <= T; i++) begin
            w_lam_upd[i] = w_lam_upd[i] ^ gf_mul(r_delta, r_b[i-1]);
        end
        if (w_swap) begin
            for (int i = 1; i <= T; i++) w_b_upd[i] = r_lam[i-1];
        end else begin
            for (int i = 2; i <= T; i++) w_b_upd[i] = r_b[i-2];
        end
    end

    // ------------------------------------------------------------------
    // Final checks: degree of Lambda against L; an all-zero Lambda
    // counts as a mismatch.
    // ------------------------------------------------------------------
    always_comb begin : p_final
        w_deg        = '0;
        w_lam_zero   = 1'b1;
        w_lam_packed = '0;
        for (int i = 0; i <= T; i++) begin
            w_lam_packed[i*M +: M] = r_lam[i];
            if (r_lam[i] != '0) begin
                w_deg      = c_JW'(i);
                w_lam_zero = 1'b0;
            end
        end
        w_fail = (r_len > c_LW'(T)) || w_lam_zero || (c_LW'(w_deg) != r_len);
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin : p_regs
        if (reset) begin
            r_state <= S_IDLE;
            r_syn   <= '0;
            for (int i = 0; i <= T; i++) begin
                r_lam[i] <= (i == 0) ? c_ONE : '0;
                r_b[i]   <= (i == 0) ? c_ONE : '0;
            end
            r_gamma  <= c_ONE;
            r_delta  <= '0;
            r_len    <= '0;
            r_r      <= '0;
            r_j      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_fail   <= 1'b0;
            r_err    <= '0;
            r_lambda <= c_LAMBDA_ONE;
        end else begin
            r_state <= w_state_next;
            r_done  <= (r_state == S_FIN);
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_syn <= syn;
                        for (int i = 0; i <= T; i++) begin
                            r_lam[i] <= (i == 0) ? c_ONE : '0;
                            r_b[i]   <= (i == 0) ? c_ONE : '0;
                        end
                        r_gamma <= c_ONE;
                        r_delta <= '0;
                        r_len   <= '0;
                        r_r     <= '0;
                        r_j     <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_DISC: begin
                    r_delta <= r_delta ^ w_prod;
                    r_j     <= r_j + c_JW'(1);
                end
                S_UPD: begin
                    r_lam <= w_lam_upd;
                    r_b   <= w_b_upd;
                    if (w_swap) begin
                        r_gamma <= r_delta;
                        r_len   <= w_len_new;
                    end
                    r_delta <= '0;
                    r_j     <= '0;
                    r_r     <= r_r + c_RW'(1);
                end
                S_FIN: begin
                    r_busy   <= 1'b0;
                    r_err    <= r_len;
                    r_fail   <= w_fail;
                    r_lambda <= w_lam_packed;
                end
                default: ;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign lambda    = r_lambda;
    assign err_count = r_err;
    assign fail      = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_tmec_decode_ibm_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tmec_decode_ibm_seq
//  Purpose  : Self-checking bench for tmec_decode_ibm_seq (M=4, T=3).
//             Fixed vector table, cycle-exact control sequences and random
//             error patterns checked against a log/antilog field model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tmec_decode_ibm_seq;

    localparam int M  = 4;
    localparam int T  = 3;
    localparam int SW = 2*T*M;
    localparam int LW = (T+1)*M;
    localparam int EW = $clog2(2*T+1);
    localparam int LAT = T*(T+2)+1;   // done edge relative to accept

    localparam logic [SW-1:0] P5 = 24'h176176;   // single error at position 5
    localparam logic [SW-1:0] P1 = 24'hC63842;   // single error at position 1
    localparam logic [SW-1:0] P0 = 24'h111111;   // single error at position 0

    logic           clk;
    logic           reset;
    logic           start;
    logic [SW-1:0]  syn;
    logic           busy;
    logic           done;
    logic [LW-1:0]  lambda;
    logic [EW-1:0]  err_count;
    logic           fail;

    tmec_decode_ibm_seq #(.M(M), .T(T)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .syn       (syn),
        .busy      (busy),
        .done      (done),
        .lambda    (lambda),
        .err_count (err_count),
        .fail      (fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    // GF(16), x^4+x+1, log/antilog tables
    int gexp [0:29];
    int glog [0:15];

    // reference model state
    int            m_pos [0:3];
    logic [SW-1:0] m_syn;
    logic [M-1:0]  m_loc [0:4];

    typedef struct {
        logic [SW-1:0] syn;
        logic [LW-1:0] lam;
        logic [EW-1:0] ec;
        logic          f;
    } vec_t;
    vec_t tbl [0:4];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [M-1:0] gmul(input logic [M-1:0] a, input logic [M-1:0] b);
        if (a == '0 || b == '0) return '0;
        return M'(gexp[glog[a] + glog[b]]);
    endfunction

    // Random distinct error positions, their syndromes and true locator.
    task automatic pick_errors(input int n);
        logic [14:0]  used;
        logic [M-1:0] s;
        logic [M-1:0] x;
        int           p;
        used = '0;
        for (int e = 0; e < n; e++) begin
            do p = $urandom_range(0, 14); while (used[p]);
            used[p]  = 1'b1;
            m_pos[e] = p;
        end
        for (int i = 1; i <= 2*T; i++) begin
            s = '0;
            for (int e = 0; e < n; e++) s = s ^ M'(gexp[(m_pos[e]*i) % 15]);
            m_syn[(i-1)*M +: M] = s;
        end
        for (int i = 0; i <= 4; i++) m_loc[i] = '0;
        m_loc[0] = 4'd1;
        for (int e = 0; e < n; e++) begin
            x = M'(gexp[m_pos[e]]);
            for (int i = 4; i >= 1; i--) m_loc[i] = m_loc[i] ^ gmul(x, m_loc[i-1]);
        end
    endtask

    function automatic logic [LW-1:0] scaled(input logic [M-1:0] c);
        logic [LW-1:0] r;
        for (int i = 0; i <= T; i++) r[i*M +: M] = gmul(c, m_loc[i]);
        return r;
    endfunction

    // Called at a negedge. Accepts one word, waits for done (bounded).
    // Returns with the bench at the negedge following the done edge.
    task automatic run_word(input logic [SW-1:0] s, output int done_k, output int busy_n);
        syn   = s;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        syn    = SW'($urandom);
        done_k = -1;
        busy_n = 0;
        for (int k = 0; k < 60; k++) begin
            if (busy) busy_n++;
            if (done) begin
                done_k = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},   32'(busy),      0);
        check({tag, "_done"},   32'(done),      0);
        check({tag, "_lambda"}, 32'(lambda),    1);
        check({tag, "_err"},    32'(err_count), 0);
        check({tag, "_fail"},   32'(fail),      0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int dk, bn, nd, nf, v;
    logic [M-1:0] lam0;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        v = 1;
        for (int i = 0; i < 30; i++) begin
            gexp[i] = v;
            if (i < 15) glog[v] = i;
            v = v << 1;
            if ((v & 16) != 0) v = v ^ 19;
        end
        glog[0] = 0;

        tbl[0] = '{syn: 24'h000000, lam: 16'h0001, ec: 3'd0, f: 1'b0};
        tbl[1] = '{syn: P5,         lam: 16'h0017, ec: 3'd1, f: 1'b0};
        tbl[2] = '{syn: P0,         lam: 16'h0011, ec: 3'd1, f: 1'b0};
        tbl[3] = '{syn: P1,         lam: 16'h0084, ec: 3'd1, f: 1'b0};
        tbl[4] = '{syn: 24'h010000, lam: 16'h0001, ec: 3'd5, f: 1'b1};

        // reset, with start held high to show reset wins
        reset = 1'b1;
        start = 1'b1;
        syn   = P5;
        repeat (3) @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        check_reset_outputs("reset");

        // fixed vectors, issued back to back
        for (int t = 0; t < 5; t++) begin
            run_word(tbl[t].syn, dk, bn);
            check("tbl_done_edge",  32'(dk),        LAT);
            check("tbl_busy_cycles", 32'(bn),       LAT);
            check("tbl_lambda",     32'(lambda),    32'(tbl[t].lam));
            check("tbl_err_count",  32'(err_count), 32'(tbl[t].ec));
            check("tbl_fail",       32'(fail),      32'(tbl[t].f));
        end

        // starts at edges 3 and 16 are ignored
        @(negedge clk);
        syn   = P5;
        start = 1'b1;
        nd = 0;
        dk = -1;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                if (dk < 0) dk = k;
            end
            start = (k == 2 || k == 15);
            syn   = (k == 2 || k == 15) ? P1 : SW'($urandom);
        end
        check("ign_done_count", 32'(nd),        1);
        check("ign_done_edge",  32'(dk),        LAT);
        check("ign_lambda",     32'(lambda),    16'h0017);
        check("ign_err_count",  32'(err_count), 1);
        check("ign_fail",       32'(fail),      0);

        // reset at edge 7 aborts, new start at edge 9
        syn   = P1;
        start = 1'b1;
        nd = 0;
        dk = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                if (dk < 0) dk = k;
            end
            if (k == 7) check_reset_outputs("midreset");
            reset = (k == 6);
            start = (k == 8);
            syn   = (k == 8) ? P5 : SW'($urandom);
        end
        check("midreset_done_count", 32'(nd),        1);
        check("midreset_done_edge",  32'(dk),        9 + LAT);
        check("midreset_lambda",     32'(lambda),    16'h0017);
        check("midreset_err_count",  32'(err_count), 1);

        // random patterns of 0..T errors
        for (int it = 0; it < 300; it++) begin
            v = $urandom_range(0, T);
            pick_errors(v);
            run_word(m_syn, dk, bn);
            lam0 = lambda[M-1:0];
            check("rand_done_edge",     32'(dk),           LAT);
            check("rand_lam0_nonzero",  32'(lam0 != '0),   1);
            check("rand_lambda",        32'(lambda),       32'(scaled(lam0)));
            check("rand_err_count",     32'(err_count),    32'(v));
            check("rand_fail",          32'(fail),         0);
        end

        // four errors: beyond capability
        nf = 0;
        for (int it = 0; it < 40; it++) begin
            pick_errors(4);
            run_word(m_syn, dk, bn);
            check("over_done_edge", 32'(dk), LAT);
            if (fail) nf++;
            if (err_count > EW'(T)) check("over_T_flag", 32'(fail), 1);
        end
        $display("4-error words with fail raised: %0d of 40", nf);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tmec_decode_ibm_seq.md
# tmec_decode_ibm_seq

Self-sequenced, parametrised key-equation solver for binary BCH decoding. It takes all 2T syndromes at once and runs the inversionless Berlekamp-Massey algorithm over GF(2^M) under an internal control FSM, so no control strobes come from outside. It returns the scaled error-locator polynomial, the error count and an uncorrectable flag. It sits between the syndrome generator and the Chien search, and replaces the externally strobed serial solver.

## Interface
- M, 4: field degree; GF(2^M), code length 2^M-1.
- T, 3: correctable errors; T >= 2.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only in IDLE.
- syn  in  2*T*M  syndromes S1..S2T; S_i at [(i-1)*M +: M]; sampled on the accepting edge only.
- busy  out  1  high from accept until done.
- done  out  1  one-cycle pulse; results valid from this cycle.
- lambda  out  (T+1)*M  locator coefficient Λ_i at [i*M +: M], i=0..T.
- err_count  out  clog2(2T+1)  final BM length L.
- fail  out  1  uncorrectable indication.

## Operation
- All field multiplies use the codebase's polynomial-basis multiply for the degree-M field. Addition is XOR.
- Registers:
  - Λ[0..T] and B[0..T], M bits per coefficient.
  - γ, δ: M bits each.
  - L: width of err_count.
  - r: iteration counter, 0..T-1.
  - j: coefficient counter, 0..T.
  - Latched syndrome bank.
- FSM states: IDLE, DISC, UPD, FIN.
- IDLE with start=1:
  - Latch syn.
  - Λ=1, B=1, γ=1, L=0, r=0, j=0, δ=0.
  - busy←1, go to DISC.
- DISC (serial discrepancy):
  - Each cycle: δ ← δ ^ Λ_j·S_(2r+1-j), with S_k=0 for k<1.
  - j increments each cycle; after j=T, go to UPD.
  - Exactly T+1 cycles, one multiplier.
- UPD (single cycle; 2(T+1) parallel multipliers):
  - Λ_i ← γ·Λ_i ^ δ·B_(i-1), with B_(-1)=0. Terms above degree T are discarded.
  - If δ≠0 and 2L ≤ 2r:
    - B_i ← Λold_(i-1) (B ← x·Λold).
    - γ←δ.
    - L ← 2r+1-L.
  - Otherwise: B_i ← B_(i-2) (B ← x²·B).
  - Clear δ and j, increment r.
  - If r was T-1, go to FIN; otherwise go to DISC.
- FIN (one cycle):
  - done=1, busy=0.
  - err_count ← L.
  - fail ← (L > T) or (deg Λ ≠ L), where deg Λ is the index of the highest nonzero Λ_i. Λ=0 counts as a degree mismatch.
  - Go to IDLE.
- lambda, err_count and fail hold until the next accepted start. The output registers are updated only in FIN.
- start while busy, or during the FIN cycle: ignored, no queuing.
- Correct operation for ≤T errors: lambda = c·Λtrue for some nonzero c. The roots of lambda are α^(-p) for each error position p. err_count equals the number of errors and fail=0.

## Timing
- Reset (overrides everything, including a simultaneous start):
  - State goes to IDLE.
  - busy=0, done=0, fail=0, err_count=0.
  - lambda = 1 (Λ_0=1, all others 0).
  - Internal registers go to their IDLE init values.
- Reset mid-operation aborts the computation. No done is produced and outputs return to their reset values.
- Accept edge is edge 0. DISC occupies T+1 cycles and UPD 1 cycle, per iteration, for T iterations.
- done is high in the cycle after edge T·(T+2)+1. For M=4, T=3 that is edge 16.
- busy is high for exactly T·(T+2)+1 cycles. It drops in the same cycle that done rises.
- Back-to-back operation: start asserted in the cycle after done is accepted, giving a throughput of T·(T+2)+2 cycles per word.
- Outputs are fully registered; no input-to-output combinational path.

## Test plan
- All-zero syn, M=4, T=3 -> done at edge 16; lambda=1, err_count=0, fail=0; busy high for 16 cycles.
- Single error at p=5 (S_i=α^(5i), M=4, T=3) -> lambda ∝ 1+α^5·x, err_count=1, fail=0; Chien roots = {α^(-5)}.
- 1000 random patterns of 0..T errors, for M=4/T=3, M=6/T=5 and M=8/T=4 -> every output matches a golden model: scalar multiple of the true locator, err_count = weight, fail=0.
- Syndromes of a 4-error pattern with T=3 -> fail=1, or the roots disagree with the injected positions. Record the rate; an err_count > T case must flag fail.
- start pulsed at edges 3 and 16 (during FIN) after an accept at edge 0 -> ignored; a single done; outputs reflect only the first syn.
- reset at edge 7 mid-run, then a new start at edge 9 -> no done from the first request; outputs at reset values; second result correct at edge 9+16.
